led_capture: RTL and testbench
==============================

// Module: led_capture
// PURPOSE
// - Receive end of the LED serial link: decodes an NRZ pulse-width stream (the format led_driver emits on
//   led_data_out) into 24-bit pixels and writes them, one per word, into a frame buffer over Wishbone (master).
// - Used for loopback self-test of led_driver and for capturing frames from an external LED controller.
// PARAMETERS
// - ADDR_WIDTH   16     Wishbone word-address width
// - DATA_WIDTH   32     Wishbone data width (>=24)
// - CLK_PER      10     clk period, ns
// - T_BIT_NS     600    high-pulse threshold: high >= T_BIT_NS -> bit 1, else bit 0
// - T_HMAX_NS    2000   high pulse longer than this is a line error
// - T_RESET_NS   50000  low time marking end of frame
// - MAX_PIXELS   1024   pixels accepted per frame; excess dropped
// PORTS
// - clk              in   1           system clock
// - reset            in   1           synchronous, active-low reset
// - wbm_address      out  ADDR_WIDTH  write address = cap_base_addr + pixel index
// - wbm_writedata    out  DATA_WIDTH  {zeros, pixel[23:0]}, first received bit at [23]
// - wbm_readdata     in   DATA_WIDTH  unused
// - wbm_strobe       out  1           Wishbone STB
// - wbm_cycle        out  1           Wishbone CYC
// - wbm_write        out  1           Wishbone WE
// - wbm_ack          in   1           Wishbone ACK
// - led_data_in      in   1           asynchronous serial input
// - cap_enable       in   1           level: capture allowed
// - cap_base_addr    in   ADDR_WIDTH  buffer base, sampled at frame start (first rising edge)
// - cap_frame_done   out  1           1-cycle pulse: frame ended and last write acked
// - cap_pixel_count  out  16          pixels written in last frame, valid from cap_frame_done
// - cap_error        out  1           sticky per frame: overflow/partial pixel/long pulse; cleared at frame start
// BEHAVIOUR
// - Reset (reset==0 at posedge): all outputs 0, FSMs to SYNC/WB_IDLE, cycle aborted without waiting for ack.
// - Input: 2-flop synchroniser then edge detect; all timing measured on synchronised signal (2-cycle latency).
// - Cycle constants: N_BIT=T_BIT_NS/CLK_PER (60), N_HMAX (200), N_RESET (5000); counters saturate.
// - Decoder FSM: SYNC -> LOW once line low N_RESET cycles (entered at reset, after error, on !cap_enable).
//   LOW: count low; rising edge -> HIGH; low count hits N_RESET with frame open -> END.
//   HIGH: count high; falling edge -> emit bit (cnt>=N_BIT), -> LOW; cnt>N_HMAX -> error, END.
//   END: close frame, -> LOW (or SYNC after error/!cap_enable).
// - Shift reg MSB-first; 24th bit -> pixel to holding reg, bit counter to 0.
// - Writer FSM WB_IDLE -> WB_WRITE when holding reg valid: STB=CYC=WE=1, addr/data stable until ack;
//   ack sampled -> all low next cycle, index+1, holding reg freed. No back-to-back in same cycle.
// - Overflow: pixel completes while holding reg still valid -> new pixel dropped, cap_error=1.
// - Index == MAX_PIXELS: further pixels dropped, cap_error=1, index not wrapped.
// - Frame end with 1..23 bits pending: partial discarded, cap_error=1.
// - cap_frame_done fires only after pending write acked; count = pixels acked. Frame with 0 pixels: no pulse.
// - cap_enable low mid-frame: current write completes, frame closed with done pulse, error=1, FSM -> SYNC.
// - Address arithmetic mod 2^ADDR_WIDTH (base+index wraps silently).
// STRUCTURE
// - Shared include led_defs.vh: timing ns constants (T0H/T1H/T_RESET) common with led_driver, bits/pixel=24.
// - Sub-module led_bit_decoder: synchroniser, pulse counters, decoder FSM; outputs bit_valid/bit_val/
//   frame_end/line_err. Top: shift reg, holding reg, Wishbone writer, status.
// TESTING
// - Loopback: mem preloaded 3 pixels 0xFF0000,0x00AA55,0x000001 -> led_driver -> led_capture base 0x100:
//   words 0x100..0x102 match, cap_pixel_count=3, cap_error=0.
// - Direct stimulus 12 bits then 50us low -> no write, cap_frame_done pulse absent, cap_error=1.
// - Slave ack delayed 40us -> second pixel dropped, cap_error=1, count=1, done after the delayed ack.
// - 2.5us high pulse -> cap_error=1, decoder resyncs; next clean frame error cleared, data correct.
// - MAX_PIXELS=2, send 4 pixels -> only 2 writes, count=2, cap_error=1.
// - reset low while wbm_cycle high -> STB/CYC/WE 0 next cycle, no done pulse, next frame captured correctly.

Source files
------------

// File: rtl/led_capture_pkg.sv
// Shared definitions for the LED serial-link capture block: link timing
// constants common with led_driver, pixel geometry and FSM state types.
package led_capture_pkg;

  // Nominal high times emitted by led_driver, and the end-of-frame low time.
  localparam int T0H_NS         = 350;
  localparam int T1H_NS         = 700;
  localparam int T_RESET_NS_DEF = 50000;

  localparam int BITS_PER_PIXEL = 24;

  typedef enum logic [1:0] {
    DEC_SYNC,
    DEC_LOW,
    DEC_HIGH,
    DEC_END
  } dec_state_e;

  typedef enum logic {
    WB_IDLE,
    WB_WRITE
  } wb_state_e;

  function automatic int ns_to_cycles(input int ns, input int clk_per);
    return ns / clk_per;
  endfunction

endpackage

// File: rtl/led_capture_bitdec.sv
// Pulse-width bit decoder: synchronises the serial line, measures high and
// low times in clock cycles and classifies them into bits and frame events.
module led_capture_bitdec
  import led_capture_pkg::*;
#(
  parameter int CLK_PER    = 10,
  parameter int T_BIT_NS   = 600,
  parameter int T_HMAX_NS  = 2000,
  parameter int T_RESET_NS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  input  logic enable_i,
  output logic bit_valid_o,
  output logic bit_val_o,
  output logic frame_start_o,
  output logic frame_end_o,
  output logic line_err_o
);

  localparam int N_BIT   = ns_to_cycles(T_BIT_NS, CLK_PER);
  localparam int N_HMAX  = ns_to_cycles(T_HMAX_NS, CLK_PER);
  localparam int N_RESET = ns_to_cycles(T_RESET_NS, CLK_PER);
  localparam int CW      = $clog2(N_RESET + 1) + 1;

  localparam logic [CW-1:0] N_BIT_C   = CW'(N_BIT);
  localparam logic [CW-1:0] N_HMAX_C  = CW'(N_HMAX);
  localparam logic [CW-1:0] N_RESET_C = CW'(N_RESET);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic          sync1_q, sync2_q;
  dec_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          open_q, open_d;
  logic          err_q, err_d;

  // Saturating duration counter; the state tracks the last level seen, so a
  // level change while in LOW or HIGH is the edge being waited for.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

  // Decoder state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DEC_SYNC;
      cnt_q   <= '0;
      open_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      open_q  <= open_d;
      err_q   <= err_d;
    end
  end

  // Decoder next state and event pulses
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    open_d        = open_q;
    err_d         = err_q;
    bit_valid_o   = 1'b0;
    bit_val_o     = 1'b0;
    frame_start_o = 1'b0;
    frame_end_o   = 1'b0;
    line_err_o    = 1'b0;
    case (state_q)
      DEC_SYNC: begin
        open_d = 1'b0;
        err_d  = 1'b0;
        if (!enable_i || sync2_q) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= N_RESET_C) state_d = DEC_LOW;
        end
      end
      DEC_LOW: begin
        if (!enable_i) begin
          cnt_d = '0;
          if (open_q) begin
            line_err_o = 1'b1;
            err_d      = 1'b1;
            state_d    = DEC_END;
          end else begin
            state_d = DEC_SYNC;
          end
        end else if (sync2_q) begin
          state_d = DEC_HIGH;
          cnt_d   = CW'(1);
          if (!open_q) begin
            open_d        = 1'b1;
            frame_start_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if (open_q && cnt_inc >= N_RESET_C) state_d = DEC_END;
        end
      end
      DEC_HIGH: begin
        if (!enable_i) begin
          line_err_o = 1'b1;
          err_d      = 1'b1;
          cnt_d      = '0;
          state_d    = DEC_END;
        end else if (!sync2_q) begin
          bit_valid_o = 1'b1;
          bit_val_o   = (cnt_q >= N_BIT_C);
          cnt_d       = CW'(1);
          state_d     = DEC_LOW;
        end else if (cnt_q > N_HMAX_C) begin
          line_err_o = 1'b1;
          err_d      = 1'b1;
          cnt_d      = '0;
          state_d    = DEC_END;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DEC_END: begin
        frame_end_o = 1'b1;
        open_d      = 1'b0;
        cnt_d       = '0;
        err_d       = 1'b0;
        state_d     = (err_q || !enable_i) ? DEC_SYNC : DEC_LOW;
      end
      default: state_d = DEC_SYNC;
    endcase
  end

endmodule

// File: rtl/led_capture.sv
// LED serial-link capture: assembles decoded bits into 24-bit pixels and
// writes them one per word into a frame buffer as a Wishbone master.
module led_capture
  import led_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_PER    = 10,
  parameter int T_BIT_NS   = 600,
  parameter int T_HMAX_NS  = 2000,
  parameter int T_RESET_NS = 50000,
  parameter int MAX_PIXELS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_strobe,
  output logic                  wbm_cycle,
  output logic                  wbm_write,
  input  logic                  wbm_ack,
  input  logic                  led_data_in,
  input  logic                  cap_enable,
  input  logic [ADDR_WIDTH-1:0] cap_base_addr,
  output logic                  cap_frame_done,
  output logic [15:0]           cap_pixel_count,
  output logic                  cap_error
);

  localparam int          BPP      = BITS_PER_PIXEL;
  localparam logic [4:0]  LAST_BIT = 5'(BPP - 1);
  localparam logic [15:0] MAX_IDX  = 16'(MAX_PIXELS);

  logic bit_valid, bit_val, frame_start, frame_end, line_err;
  logic unused_rd;

  logic [BPP-1:0]        sh_q, sh_d, hold_q, hold_d, pix_next;
  logic [4:0]            bcnt_q, bcnt_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           idx_q, idx_d, count_q, count_d;
  logic                  end_pend_q, end_pend_d;
  logic                  err_q, err_d, done_q, done_d;
  wb_state_e             wb_q, wb_d;
  logic                  wr_done;

  // Write-only master: read data is never consumed.
  assign unused_rd = ^wbm_readdata;

  led_capture_bitdec #(
    .CLK_PER   (CLK_PER),
    .T_BIT_NS  (T_BIT_NS),
    .T_HMAX_NS (T_HMAX_NS),
    .T_RESET_NS(T_RESET_NS)
  ) u_dec (
    .clk          (clk),
    .reset        (reset),
    .line_i       (led_data_in),
    .enable_i     (cap_enable),
    .bit_valid_o  (bit_valid),
    .bit_val_o    (bit_val),
    .frame_start_o(frame_start),
    .frame_end_o  (frame_end),
    .line_err_o   (line_err)
  );

  assign pix_next = {sh_q[BPP-2:0], bit_val};

  // Wishbone writer next state: one single-beat write per held pixel
  always_comb begin
    wb_d    = wb_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_done = 1'b0;
    case (wb_q)
      WB_IDLE: begin
        if (hold_vld_q) begin
          wb_d   = WB_WRITE;
          addr_d = base_q + ADDR_WIDTH'(idx_q);
          data_d = DATA_WIDTH'(hold_q);
        end
      end
      WB_WRITE: begin
        if (wbm_ack) begin
          wb_d    = WB_IDLE;
          wr_done = 1'b1;
        end
      end
      default: wb_d = WB_IDLE;
    endcase
  end

  // Pixel assembly, drop policy, error and frame-done status
  always_comb begin
    sh_d       = sh_q;
    hold_d     = hold_q;
    bcnt_d     = bcnt_q;
    hold_vld_d = hold_vld_q;
    base_d     = base_q;
    idx_d      = idx_q;
    count_d    = count_q;
    end_pend_d = end_pend_q;
    err_d      = err_q;
    done_d     = 1'b0;

    if (wr_done) begin
      idx_d      = idx_q + 16'd1;
      hold_vld_d = 1'b0;
    end

    if (frame_start) begin
      base_d = cap_base_addr;
      idx_d  = '0;
      bcnt_d = '0;
      err_d  = 1'b0;
    end

    if (bit_valid) begin
      sh_d = pix_next;
      if (bcnt_q == LAST_BIT) begin
        bcnt_d = '0;
        // A full holding register or an exhausted buffer drops the pixel.
        if (hold_vld_q || idx_q >= MAX_IDX) begin
          err_d = 1'b1;
        end else begin
          hold_d     = pix_next;
          hold_vld_d = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + 5'd1;
      end
    end

    if (line_err) err_d = 1'b1;

    if (frame_end) begin
      if (bcnt_q != '0) err_d = 1'b1;
      bcnt_d     = '0;
      end_pend_d = 1'b1;
    end

    // Report the frame only once the last write has been acknowledged.
    if (end_pend_q && !hold_vld_q) begin
      end_pend_d = 1'b0;
      if (idx_q != '0) begin
        done_d  = 1'b1;
        count_d = idx_q;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q       <= WB_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      bcnt_q     <= '0;
      hold_vld_q <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      end_pend_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      bcnt_q     <= bcnt_d;
      hold_vld_q <= hold_vld_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      end_pend_q <= end_pend_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Pixel data registers, qualified by the control state above
  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    hold_q <= hold_d;
    base_q <= base_d;
  end

  assign wbm_address     = addr_q;
  assign wbm_writedata   = data_q;
  assign wbm_strobe      = (wb_q == WB_WRITE);
  assign wbm_cycle       = (wb_q == WB_WRITE);
  assign wbm_write       = (wb_q == WB_WRITE);
  assign cap_frame_done  = done_q;
  assign cap_pixel_count = count_q;
  assign cap_error       = err_q;

endmodule

// File: tb/tb_led_capture.sv
// Bench for led_capture: drives pulse-width frames on the serial line, acts as
// a Wishbone slave and compares captured words and status to a frame model.
module tb_led_capture;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int MAXP   = 4;
  localparam int H0     = 4;    // high cycles for a 0 bit (threshold 10)
  localparam int H1     = 16;   // high cycles for a 1 bit (max 30)
  localparam int LOWC   = 6;    // low cycles between bits
  localparam int GAP    = 600;  // low cycles after a frame (end-of-frame is 500)

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] wbm_address;
  logic [DW-1:0] wbm_writedata;
  logic [DW-1:0] wbm_readdata;
  logic          wbm_strobe, wbm_cycle, wbm_write, wbm_ack;
  logic          led_data_in;
  logic          cap_enable;
  logic [AW-1:0] cap_base_addr;
  logic          cap_frame_done;
  logic [15:0]   cap_pixel_count;
  logic          cap_error;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_delay = 0;
  int          done_cnt = 0;
  logic [15:0] last_count;
  logic        last_err;
  wr_t         wr_q[$];
  logic [23:0] pix_q[$];

  always #5 clk = ~clk;

  led_capture #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CLK_PER   (10),
    .T_BIT_NS  (100),
    .T_HMAX_NS (300),
    .T_RESET_NS(5000),
    .MAX_PIXELS(MAXP)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .wbm_address    (wbm_address),
    .wbm_writedata  (wbm_writedata),
    .wbm_readdata   (wbm_readdata),
    .wbm_strobe     (wbm_strobe),
    .wbm_cycle      (wbm_cycle),
    .wbm_write      (wbm_write),
    .wbm_ack        (wbm_ack),
    .led_data_in    (led_data_in),
    .cap_enable     (cap_enable),
    .cap_base_addr  (cap_base_addr),
    .cap_frame_done (cap_frame_done),
    .cap_pixel_count(cap_pixel_count),
    .cap_error      (cap_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave: acks after ack_delay stalled cycles and logs each write.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    wbm_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (wbm_ack) begin
        wbm_ack = 1'b0;
      end else if (wbm_strobe && wbm_cycle) begin
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          wbm_ack  = 1'b1;
          wr_q.push_back('{a: wbm_address, d: wbm_writedata});
          chk("wb_we", 64'(wbm_write), 64'd1);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Frame-done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (cap_frame_done) begin
        done_cnt++;
        last_count = cap_pixel_count;
        last_err   = cap_error;
      end
    end
  end

  task automatic send_bit(input logic b);
    led_data_in = 1'b1;
    repeat (b ? H1 : H0) @(negedge clk);
    led_data_in = 1'b0;
    repeat (LOWC) @(negedge clk);
  endtask

  task automatic send_pixels();
    foreach (pix_q[i]) begin
      for (int b = 23; b >= 0; b--) send_bit(pix_q[i][b]);
    end
  endtask

  task automatic fill_random(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(24'($urandom));
  endtask

  // Sends pix_q plus `partial` stray bits, then checks the frame outcome.
  // The model: pixels land in order at base+i until the buffer limit; a slow
  // slave keeps only the first pixel; any drop, stray bit or abort is an error.
  task automatic do_frame(input int partial, input bit abort, input bit slow,
                          input logic [AW-1:0] base);
    int n, acc, base_done, base_wr, nwr, ndone, t;
    bit exp_err, exp_done;
    n = pix_q.size();
    if (!slow) ack_delay = $urandom_range(0, 3);
    cap_base_addr = base;
    base_done = done_cnt;
    base_wr   = wr_q.size();
    send_pixels();
    for (int i = 0; i < partial; i++) send_bit(1'($urandom));
    if (abort) begin
      cap_enable = 1'b0;
      repeat (10) @(negedge clk);
      cap_enable = 1'b1;
    end

    if (slow) acc = (n > 0) ? 1 : 0;
    else      acc = (n < MAXP) ? n : MAXP;
    exp_err  = (n > acc) || (partial != 0) || abort;
    exp_done = (acc > 0);

    repeat (GAP) @(negedge clk);
    t = 0;
    while (exp_done && done_cnt == base_done && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);

    ndone = done_cnt - base_done;
    nwr   = wr_q.size() - base_wr;
    chk("done_pulses", 64'(ndone), exp_done ? 64'd1 : 64'd0);
    if (ndone > 0) begin
      chk("pixel_count", 64'(last_count), 64'(acc));
      chk("err_at_done", 64'(last_err), 64'(exp_err));
    end
    chk("cap_error", 64'(cap_error), 64'(exp_err));
    chk("n_writes", 64'(nwr), 64'(acc));
    for (int i = 0; i < acc && i < nwr; i++) begin
      chk("wr_addr", 64'(wr_q[base_wr+i].a), 64'(AW'(base + AW'(i))));
      chk("wr_data", 64'(wr_q[base_wr+i].d), 64'({8'h00, pix_q[i]}));
    end
  endtask

  initial begin
    int base_done, base_wr;
    reset         = 1'b0;
    led_data_in   = 1'b0;
    cap_enable    = 1'b1;
    cap_base_addr = '0;
    wbm_readdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr",  64'(wbm_address), 64'd0);
    chk("rst_data",  64'(wbm_writedata), 64'd0);
    chk("rst_stb",   64'(wbm_strobe), 64'd0);
    chk("rst_cyc",   64'(wbm_cycle), 64'd0);
    chk("rst_we",    64'(wbm_write), 64'd0);
    chk("rst_done",  64'(cap_frame_done), 64'd0);
    chk("rst_count", 64'(cap_pixel_count), 64'd0);
    chk("rst_err",   64'(cap_error), 64'd0);
    reset = 1'b1;
    repeat (GAP) @(negedge clk);

    // Loopback pattern
    pix_q = '{24'hFF0000, 24'h00AA55, 24'h000001};
    do_frame(0, 1'b0, 1'b0, 16'h0100);

    // Random frames, some over the buffer limit, some with stray bits
    for (int k = 0; k < 6; k++) begin
      fill_random($urandom_range(1, 6));
      do_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 23) : 0,
               1'b0, 1'b0, 16'($urandom));
    end

    // Address wrap at the top of the space
    fill_random(4);
    do_frame(0, 1'b0, 1'b0, 16'hFFFE);

    // Twelve bits only: no write, no done, error
    pix_q.delete();
    do_frame(12, 1'b0, 1'b0, 16'h0200);

    // Slow slave: second pixel overruns the holding register
    fill_random(2);
    ack_delay = 1500;
    do_frame(0, 1'b0, 1'b1, 16'h0300);
    ack_delay = 0;

    // Buffer limit: six pixels sent, four written
    fill_random(6);
    do_frame(0, 1'b0, 1'b0, 16'h0400);

    // Over-long high pulse, then a clean frame clears the error
    base_done = done_cnt;
    base_wr   = wr_q.size();
    led_data_in = 1'b1;
    repeat (40) @(negedge clk);
    led_data_in = 1'b0;
    repeat (GAP) @(negedge clk);
    chk("long_err",    64'(cap_error), 64'd1);
    chk("long_done",   64'(done_cnt - base_done), 64'd0);
    chk("long_writes", 64'(wr_q.size() - base_wr), 64'd0);
    fill_random(3);
    do_frame(0, 1'b0, 1'b0, 16'h0500);

    // Capture disabled mid-frame
    fill_random(2);
    do_frame(0, 1'b1, 1'b0, 16'h0600);

    // Reset while a write is outstanding
    base_done = done_cnt;
    base_wr   = wr_q.size();
    ack_delay = 100000;
    pix_q = '{24'h123456};
    cap_base_addr = 16'h0700;
    send_pixels();
    repeat (5) @(negedge clk);
    chk("busy_stb", 64'(wbm_strobe), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_stb",   64'(wbm_strobe), 64'd0);
    chk("abort_cyc",   64'(wbm_cycle), 64'd0);
    chk("abort_we",    64'(wbm_write), 64'd0);
    chk("abort_count", 64'(cap_pixel_count), 64'd0);
    @(negedge clk);
    reset     = 1'b1;
    ack_delay = 0;
    repeat (GAP + 100) @(negedge clk);
    chk("abort_done",   64'(done_cnt - base_done), 64'd0);
    chk("abort_writes", 64'(wr_q.size() - base_wr), 64'd0);
    fill_random(3);
    do_frame(0, 1'b0, 1'b0, 16'h0800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
